// File: rtl/md_unit_pkg.sv
// Shared constants for the multiply/divide unit: opcode encodings,
// sequencer state encoding and counter sizing helpers.
package md_unit_pkg;

  localparam logic [3:0] MD_NOP   = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MADD  = 4'd5;
  localparam logic [3:0] MD_MADDU = 4'd6;
  localparam logic [3:0] MD_MSUB  = 4'd7;
  localparam logic [3:0] MD_MSUBU = 4'd8;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  function automatic logic md_is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Busy counter only needs to hold LAT-1; keep at least one bit.
  function automatic int md_cnt_w(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/md_calc.sv
// md_calc: combinational 64-bit mult/div/accumulate result from op, a, b
// and the current {HI,LO}. valid flags an opcode this build accepts.
// Optional feature macro: MD_MACC_EN enables madd/maddu/msub/msubu.
module md_calc
  import md_unit_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result,
  output logic        valid
);

  logic [63:0] sprod, uprod, acc;
  logic [31:0] mag_a, mag_b, mag_q, mag_r, quo, rem, uquo, urem;

  assign acc   = {hi, lo};
  assign sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign uprod = {32'd0, a} * {32'd0, b};

  // Signed divide via magnitudes so 0x80000000 / -1 wraps instead of overflowing.
  assign mag_a = a[31] ? -a : a;
  assign mag_b = b[31] ? -b : b;
  assign mag_q = mag_a / mag_b;
  assign mag_r = mag_a % mag_b;
  assign quo   = (a[31] ^ b[31]) ? -mag_q : mag_q;
  assign rem   = a[31] ? -mag_r : mag_r;
  assign uquo  = a / b;
  assign urem  = a % b;

  // Select the result for the opcode; divide by zero keeps {HI,LO}.
  always_comb begin
    result = acc;
    valid  = 1'b0;
    case (op)
      MD_MULT:  begin result = sprod; valid = 1'b1; end
      MD_MULTU: begin result = uprod; valid = 1'b1; end
      MD_DIV: begin
        valid = 1'b1;
        if (b != 32'd0) result = {rem, quo};
      end
      MD_DIVU: begin
        valid = 1'b1;
        if (b != 32'd0) result = {urem, uquo};
      end
`ifdef MD_MACC_EN
      MD_MADD:  begin result = acc + sprod; valid = 1'b1; end
      MD_MADDU: begin result = acc + uprod; valid = 1'b1; end
      MD_MSUB:  begin result = acc - sprod; valid = 1'b1; end
      MD_MSUBU: begin result = acc - uprod; valid = 1'b1; end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit with HI/LO, busy sequencing and
// D-stage stall request. Optional feature macro: MD_MACC_EN (see md_calc).
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   MD_IDLE | no op in flight; accepts start, mthi/mtlo writes
//   MD_RUN  | op in flight; counter counts down to 0, then commits {HI,LO}
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  input  logic        rd_hi,
  input  logic        md_instr_d,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        stall
);

  localparam int CW = md_cnt_w(DIV_LAT);
  localparam logic [CW-1:0] MULT_TC = CW'(MULT_LAT - 1);
  localparam logic [CW-1:0] DIV_TC  = CW'(DIV_LAT - 1);

  md_state_e   state;
  logic [CW-1:0] cnt;
  logic [31:0] hi, lo, sh, sl;
  logic [63:0] calc_result;
  logic        calc_valid;

  md_calc u_calc (
    .op     (op),
    .a      (a),
    .b      (b),
    .hi     (hi),
    .lo     (lo),
    .result (calc_result),
    .valid  (calc_valid)
  );

  assign rdata = rd_hi ? hi : lo;
  assign stall = md_instr_d & (start | busy);

  // Sequencer: latch result into shadow at issue, commit to HI/LO at terminal count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MD_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      sh    <= '0;
      sl    <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            // start takes priority; any same-cycle mthi/mtlo is dropped
            if (calc_valid) begin
              {sh, sl} <= calc_result;
              cnt      <= md_is_div(op) ? DIV_TC : MULT_TC;
              busy     <= 1'b1;
              state    <= MD_RUN;
            end
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        MD_RUN: begin
          if (cnt == '0) begin
            hi    <= sh;
            lo    <= sl;
            busy  <= 1'b0;
            state <= MD_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Testbench for md_unit: directed scenarios plus randomized traffic, all
// checked against a cycle-level reference model of HI/LO and busy time.
module tb_md_unit;
  import md_unit_pkg::*;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk = 1'b0;
  logic        reset, start, hi_we, lo_we, rd_hi, md_instr_d;
  logic [3:0]  op;
  logic [31:0] a, b, wdata, rdata;
  logic        busy, stall;

  always #5 clk = ~clk;

  md_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .hi_we      (hi_we),
    .lo_we      (lo_we),
    .wdata      (wdata),
    .rd_hi      (rd_hi),
    .md_instr_d (md_instr_d),
    .rdata      (rdata),
    .busy       (busy),
    .stall      (stall)
  );

  int vectors = 0;
  int miscompares = 0;

  bit [31:0] m_hi, m_lo;
  bit [63:0] m_pend;
  int        m_left;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_known(input bit [3:0] o);
    if (o == MD_MULT || o == MD_MULTU || o == MD_DIV || o == MD_DIVU) return 1'b1;
`ifdef MD_MACC_EN
    if (o == MD_MADD || o == MD_MADDU || o == MD_MSUB || o == MD_MSUBU) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic bit [63:0] ref_result(input bit [3:0] o, input bit [31:0] x, input bit [31:0] y,
                                           input bit [31:0] h, input bit [31:0] l);
    longint          sp  = longint'($signed(x)) * longint'($signed(y));
    longint unsigned up  = {32'd0, x} * {32'd0, y};
    bit [63:0]       acc = {h, l};
    int              sx  = x;
    int              sy  = y;
    int              q, r;
    case (o)
      MD_MULT:  return sp;
      MD_MULTU: return up;
      MD_DIV: begin
        if (y == 0) return acc;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sx / sy;
        r = sx % sy;
        return {r, q};
      end
      MD_DIVU:  return (y == 0) ? acc : {x % y, x / y};
      MD_MADD:  return acc + sp;
      MD_MADDU: return acc + up;
      MD_MSUB:  return acc - sp;
      MD_MSUBU: return acc - up;
      default:  return acc;
    endcase
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_hi = 0; m_lo = 0; m_pend = 0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) {m_hi, m_lo} = m_pend;
    end else if (start) begin
      if (ref_known(op)) begin
        m_pend = ref_result(op, a, b, m_hi, m_lo);
        m_left = (op == MD_DIV || op == MD_DIVU) ? DIV_LAT : MULT_LAT;
      end
    end else begin
      if (hi_we) m_hi = wdata;
      if (lo_we) m_lo = wdata;
    end
  endtask

  // Check outputs for the current inputs, then advance one clock.
  task automatic cycle();
    #1;
    check_val("rdata", rdata, rd_hi ? m_hi : m_lo);
    check_val("busy",  busy,  m_left > 0);
    check_val("stall", stall, md_instr_d & (start | (m_left > 0)));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_idle();
    reset = 0; start = 0; op = MD_NOP; a = 0; b = 0;
    hi_we = 0; lo_we = 0; wdata = 0;
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1; op = o; a = x; b = y;
    cycle();
    start = 0; op = MD_NOP;
  endtask

  task automatic wait_idle(input string tag, input int exp_cycles);
    int n = 0;
    while (busy === 1'b1 && n < 50) begin
      cycle();
      n++;
    end
    check_val(tag, n, exp_cycles);
  endtask

  task automatic peek(input logic sel, input logic [31:0] exp, input string tag);
    rd_hi = sel;
    #1;
    check_val(tag, rdata, exp);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    set_idle();
    rd_hi = 0; md_instr_d = 0;
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_hi = 0; m_lo = 0; m_pend = 0; m_left = 0;
    md_instr_d = 1; start = 1;
    cycle();                       // reset held: stall follows start only
    set_idle(); md_instr_d = 0;

    // mult signed
    issue(MD_MULT, 32'd7, 32'hFFFF_FFFD);
    wait_idle("mult_lat", MULT_LAT);
    peek(0, 32'hFFFF_FFEB, "mult_lo");
    peek(1, 32'hFFFF_FFFF, "mult_hi");

    // div signed, then divu by zero keeps HI/LO
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle("div_lat", DIV_LAT);
    peek(0, 32'hFFFF_FFFD, "div_lo");
    peek(1, 32'hFFFF_FFFF, "div_hi");
    issue(MD_DIVU, 32'd7, 32'd0);
    wait_idle("divu0_lat", DIV_LAT);
    peek(0, 32'hFFFF_FFFD, "divu0_lo");
    peek(1, 32'hFFFF_FFFF, "divu0_hi");

    // most-negative / -1
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("ovf_lat", DIV_LAT);
    peek(0, 32'h8000_0000, "ovf_lo");
    peek(1, 32'h0, "ovf_hi");

    // stall across a whole op, then a back-to-back accept
    md_instr_d = 1;
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_idle("multu_lat", MULT_LAT);
    #1 check_val("stall_free", stall, 1'b0);
    issue(MD_MULT, 32'd3, 32'd4);
    check_val("restart_busy", busy, 1'b1);
    md_instr_d = 0;
    wait_idle("restart_lat", MULT_LAT);
    peek(0, 32'd12, "restart_lo");

    // reset on the third busy cycle of divu
    issue(MD_DIVU, 32'd100, 32'd7);
    cycle();
    cycle();
    reset = 1;
    cycle();
    reset = 0;
    check_val("rst_busy", busy, 1'b0);
    peek(0, 32'd0, "rst_lo");
    peek(1, 32'd0, "rst_hi");
    repeat (12) cycle();
    peek(0, 32'd0, "rst_nocommit");

    // mthi in idle, mtlo ignored while busy
    hi_we = 1; wdata = 32'h1234_5678;
    cycle();
    hi_we = 0;
    peek(1, 32'h1234_5678, "mthi");
    issue(MD_MULT, 32'd2, 32'd2);
    lo_we = 1; wdata = 32'hDEAD_BEEF;
    cycle();
    lo_we = 0;
    peek(0, 32'd0, "mtlo_busy");
    wait_idle("mtlo_lat", MULT_LAT - 1);

    // multiply-accumulate (or its absence)
    hi_we = 1; wdata = 32'd0;
    cycle();
    hi_we = 0; lo_we = 1; wdata = 32'd10;
    cycle();
    lo_we = 0;
    issue(MD_MSUB, 32'd2, 32'd3);
`ifdef MD_MACC_EN
    wait_idle("msub_lat", MULT_LAT);
    peek(0, 32'd4, "msub_lo");
    peek(1, 32'd0, "msub_hi");
`else
    check_val("msub_busy", busy, 1'b0);
    peek(0, 32'd10, "msub_lo");
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 99) == 0);
      start      = ($urandom_range(0, 3) == 0);
      op         = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
      a          = pick();
      b          = pick();
      hi_we      = ($urandom_range(0, 5) == 0);
      lo_we      = ($urandom_range(0, 5) == 0);
      wdata      = $urandom;
      rd_hi      = 1'($urandom_range(0, 1));
      md_instr_d = 1'($urandom_range(0, 1));
      cycle();
    end
    set_idle();
    repeat (DIV_LAT + 2) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
